// File: rtl/haze_frame_sequencer.sv
// haze_frame_sequencer: two-pass frame controller (ALE pass, ALE wait, dehaze pass, drain)
//   ACLK/ARESETn       clock, async active-low reset
//   enable             start/continue frames, sampled only in IDLE
//   s_valid/s_last     input stream handshake and framing check, s_ready gates the stream
//   fifo_ready         output buffer not prog-full
//   ale_done           ALE result valid, ale_clear restarts ALE at frame start
//   ale_enable/te_enable  registered stage enables for the clock-gating cells
//   m_valid/m_ready    output stream handshake, m_last marks beat N-1
//   frame_done         pulse after the final output beat
//   state              current state code
//   tlast_err/ale_timeout  sticky error flags, cleared at frame start
module haze_frame_sequencer #(
   parameter int IMG_WIDTH   = 512,
   parameter int IMG_HEIGHT  = 512,
   parameter int CNT_W       = 20,
   parameter int ALE_TIMEOUT = 4096
) (
   input  logic       ACLK,
   input  logic       ARESETn,
   input  logic       enable,
   input  logic       s_valid,
   input  logic       s_last,
   input  logic       fifo_ready,
   output logic       s_ready,
   input  logic       ale_done,
   output logic       ale_clear,
   output logic       ale_enable,
   output logic       te_enable,
   input  logic       m_valid,
   input  logic       m_ready,
   output logic       m_last,
   output logic       frame_done,
   output logic [2:0] state,
   output logic       tlast_err,
   output logic       ale_timeout
);
   typedef enum logic [2:0] {IDLE = 3'd0, ALE_PASS = 3'd1, ALE_WAIT = 3'd2, DEHAZE_PASS = 3'd3, DRAIN = 3'd4} state_e;
   localparam int N  = IMG_WIDTH * IMG_HEIGHT;
   localparam int WW = $clog2(ALE_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST      = CNT_W'(N - 1);
   localparam logic [WW-1:0]    WAIT_LAST = WW'(ALE_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
   logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
   logic             tlast_err_q, tlast_err_d, ale_timeout_q, ale_timeout_d;
   logic             frame_done_q, ale_en_q, te_en_q;
   logic             in_pass, out_pass, in_beat, out_beat, in_final, out_final, start;

   assign in_pass   = state_q == ALE_PASS || state_q == DEHAZE_PASS;
   assign out_pass  = state_q == DEHAZE_PASS || state_q == DRAIN;
   assign s_ready   = in_pass & fifo_ready;
   assign in_beat   = s_valid & s_ready;
   assign out_beat  = m_valid & m_ready & out_pass;
   assign in_final  = in_beat & (in_cnt_q == LAST);
   assign out_final = out_beat & (out_cnt_q == LAST);
   assign m_last    = m_valid & out_pass & (out_cnt_q == LAST);
   assign start     = state_q == IDLE && enable;
   // gated by reset so the pulse cannot appear while the block is held in reset
   assign ale_clear = start & ARESETn;

   assign state       = state_q;
   assign tlast_err   = tlast_err_q;
   assign ale_timeout = ale_timeout_q;
   assign frame_done  = frame_done_q;
   assign ale_enable  = ale_en_q;
   assign te_enable   = te_en_q;

   always_comb begin
      state_d       = state_q;
      in_cnt_d      = in_beat ? (in_final ? '0 : in_cnt_q + 1'b1) : in_cnt_q;
      out_cnt_d     = out_beat ? (out_final ? '0 : out_cnt_q + 1'b1) : out_cnt_q;
      wait_cnt_d    = '0;
      // a beat is mis-framed when s_last disagrees with "this is beat N-1"
      tlast_err_d   = start ? 1'b0 : tlast_err_q | (in_beat & (s_last != (in_cnt_q == LAST)));
      ale_timeout_d = start ? 1'b0 : ale_timeout_q;
      case (state_q)
         IDLE:        if (enable) state_d = ALE_PASS;
         ALE_PASS:    if (in_final) state_d = ALE_WAIT;
         ALE_WAIT: begin
            wait_cnt_d = (ale_done || wait_cnt_q == WAIT_LAST) ? '0 : wait_cnt_q + 1'b1;
            if (ale_done) state_d = DEHAZE_PASS;
            else if (wait_cnt_q == WAIT_LAST) begin
               state_d       = DEHAZE_PASS;
               ale_timeout_d = 1'b1;
            end
         end
         DEHAZE_PASS: if (in_final) state_d = out_final ? IDLE : DRAIN;
         DRAIN:       if (out_final) state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   // enables come straight from flops (next-state decoded) so the gating latches see no glitches
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q       <= IDLE;
         in_cnt_q      <= '0;
         out_cnt_q     <= '0;
         wait_cnt_q    <= '0;
         tlast_err_q   <= 1'b0;
         ale_timeout_q <= 1'b0;
         frame_done_q  <= 1'b0;
         ale_en_q      <= 1'b0;
         te_en_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         in_cnt_q      <= in_cnt_d;
         out_cnt_q     <= out_cnt_d;
         wait_cnt_q    <= wait_cnt_d;
         tlast_err_q   <= tlast_err_d;
         ale_timeout_q <= ale_timeout_d;
         frame_done_q  <= out_final;
         ale_en_q      <= state_d == ALE_PASS || state_d == ALE_WAIT;
         te_en_q       <= state_d == DEHAZE_PASS || state_d == DRAIN;
      end
   end
endmodule

// File: tb/tb_haze_frame_sequencer.sv
// tb_haze_frame_sequencer: randomized frame-level bench with a phase-driven reference model
module tb_haze_frame_sequencer;
   localparam int N = 16;
   localparam int T = 8;
   logic       clk = 1'b0, rst_n;
   logic       enable, s_valid, s_last, fifo_ready, ale_done, m_valid, m_ready;
   logic       s_ready, ale_clear, ale_enable, te_enable, m_last, frame_done, tlast_err, ale_timeout;
   logic [2:0] state;
   int         pass_n = 0, total_n = 0;
   int         ins, outs;
   bit         err_m, to_m, fd_m;

   haze_frame_sequencer #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .CNT_W(20), .ALE_TIMEOUT(T)) dut (
      .ACLK(clk), .ARESETn(rst_n), .enable(enable), .s_valid(s_valid), .s_last(s_last),
      .fifo_ready(fifo_ready), .s_ready(s_ready), .ale_done(ale_done), .ale_clear(ale_clear),
      .ale_enable(ale_enable), .te_enable(te_enable), .m_valid(m_valid), .m_ready(m_ready),
      .m_last(m_last), .frame_done(frame_done), .state(state), .tlast_err(tlast_err),
      .ale_timeout(ale_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      total_n++;
      if (got == exp) pass_n++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic common(input int st);
      chk("state", int'(state), st);
      chk("ale_enable", int'(ale_enable), int'(st == 1 || st == 2));
      chk("te_enable", int'(te_enable), int'(st == 3 || st == 4));
      chk("frame_done", int'(frame_done), int'(fd_m));
      chk("tlast_err", int'(tlast_err), int'(err_m));
      chk("ale_timeout", int'(ale_timeout), int'(to_m));
   endtask

   task automatic zero_check(input string tag);
      chk({tag, "_state"}, int'(state), 0);
      chk({tag, "_outs"}, int'({s_ready, ale_clear, ale_enable, te_enable, m_last, frame_done, tlast_err, ale_timeout}), 0);
   endtask

   task automatic start_frame();
      @(negedge clk);
      enable = 1'b1; ale_done = 1'b0; m_valid = 1'b0; s_valid = 1'($urandom); fifo_ready = 1'b1;
      #1;
      common(0);
      chk("ale_clear_start", int'(ale_clear), 1);
      chk("s_ready_idle", int'(s_ready), 0);
      tick();
      fd_m = 0; err_m = 0; to_m = 0; ins = 0; outs = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         enable = 1'b0; s_valid = 1'($urandom); fifo_ready = 1'($urandom); m_valid = 1'b1; m_ready = 1'($urandom);
         #1;
         common(0);
         chk("ale_clear_idle", int'(ale_clear), 0);
         chk("s_ready_idle", int'(s_ready), 0);
         chk("m_last_idle", int'(m_last), 0);
         tick();
         fd_m = 0;
      end
   endtask

   // bp=1 holds s_valid and toggles fifo_ready; mirror drives an output beat with every input beat
   task automatic feed(input int st, input bit bp, input int err_beat, input bit drop_last, input bit mirror, input int abort_at);
      int guard = 0;
      bit tog = 1'b0;
      while (ins < N && ins != abort_at && guard < 300) begin
         @(negedge clk);
         fifo_ready = bp ? tog : ($urandom_range(0, 3) != 0);
         tog = !tog;
         s_valid = bp ? 1'b1 : ($urandom_range(0, 3) != 0);
         s_last = s_valid ? ((ins == N - 1 && !drop_last) || ins == err_beat - 1) : 1'($urandom);
         m_valid = mirror ? s_valid : (st == 1 ? 1'($urandom) : 1'b0);
         m_ready = mirror ? fifo_ready : 1'($urandom);
         #1;
         common(st);
         chk("s_ready", int'(s_ready), int'(fifo_ready));
         chk("ale_clear", int'(ale_clear), 0);
         chk("m_last", int'(m_last), int'(st == 3 && m_valid && outs == N - 1));
         tick();
         fd_m = 0;
         if (s_valid && fifo_ready) begin
            if (s_last != (ins == N - 1)) err_m = 1;
            ins++;
         end
         if (mirror && m_valid && m_ready) begin
            fd_m = outs == N - 1;
            outs++;
         end
         guard++;
      end
      if (guard >= 300) chk("feed_budget", guard, 0);
   endtask

   task automatic wait_phase(input int dly);
      int n = dly < T ? dly + 1 : T;
      ins = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ale_done = i >= dly; s_valid = 1'($urandom); fifo_ready = 1'($urandom);
         m_valid = 1'($urandom); m_ready = 1'($urandom);
         #1;
         common(2);
         chk("s_ready_wait", int'(s_ready), 0);
         chk("m_last_wait", int'(m_last), 0);
         tick();
      end
      to_m = dly >= T;
   endtask

   task automatic drain(input bit stall);
      int guard = 0, held = 0;
      while (outs < N && guard < 300) begin
         @(negedge clk);
         s_valid = 1'($urandom); fifo_ready = 1'($urandom); m_valid = 1'($urandom); m_ready = 1'($urandom);
         if (stall && outs == N - 1 && held < 4) begin
            m_valid = 1'b1; m_ready = 1'b0; held++;
         end
         #1;
         common(4);
         chk("s_ready_drain", int'(s_ready), 0);
         chk("m_last", int'(m_last), int'(m_valid && outs == N - 1));
         tick();
         fd_m = 0;
         if (m_valid && m_ready) begin
            fd_m = outs == N - 1;
            outs++;
         end
         guard++;
      end
      if (guard >= 300) chk("drain_budget", guard, 0);
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_last = 1'b0; fifo_ready = 1'b0;
      ale_done = 1'b0; m_valid = 1'b0; m_ready = 1'b0;
      fd_m = 0; err_m = 0; to_m = 0; ins = 0; outs = 0;
      #12;
      zero_check("reset");
      @(negedge clk);
      rst_n = 1'b1;
      // nominal frame
      start_frame();
      feed(1, 0, 0, 0, 0, -1); wait_phase(3); feed(3, 0, 0, 0, 0, -1); drain(0);
      // back-to-back: backpressure, ALE timeout, output stall on the last beat
      start_frame();
      feed(1, 1, 0, 0, 0, -1); wait_phase(100); feed(3, 1, 0, 0, 0, -1); drain(1);
      // framing errors, ale_done on the timeout cycle, last in/out beats coincide
      start_frame();
      feed(1, 0, 10, 1, 0, -1); wait_phase(T - 1); feed(3, 0, 0, 0, 1, -1);
      // enable dropped mid-frame: frame completes, then stays idle
      start_frame();
      enable = 1'b0;
      feed(1, 0, 0, 0, 0, -1); wait_phase(0); feed(3, 0, 0, 0, 0, -1); drain(0);
      idle(3);
      // reset in the middle of the dehaze pass with both sticky flags set
      start_frame();
      feed(1, 0, 3, 0, 0, -1); wait_phase(50); feed(3, 0, 0, 0, 0, 7);
      @(negedge clk);
      enable = 1'b1; fifo_ready = 1'b1; s_valid = 1'b1; m_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      zero_check("async_reset");
      @(negedge clk);
      enable = 1'b0;
      rst_n = 1'b1;
      fd_m = 0; err_m = 0; to_m = 0;
      start_frame();
      feed(1, 0, 0, 0, 0, -1); wait_phase(2); feed(3, 0, 0, 0, 0, -1); drain(0);
      idle(2);
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end
endmodule

// File: doc/haze_frame_sequencer.md
Name: haze_frame_sequencer

Overview:
Frame-level controller for the haze-removal pipeline. Each frame is streamed in twice. The first pass feeds atmospheric light estimation (ALE). The second pass feeds transmission estimation and scene recovery (TE_SRSC). The block gates the input stream between passes, drives the ALE/TE_SRSC enables that feed the clock-gating cells, counts output beats to generate M_AXIS_TLAST, and reports frame completion and framing errors. It sits between the AXI4-Stream slave port, the window generator, the two processing stages and the output buffer.

Parameters:
IMG_WIDTH, 512, pixels per line
IMG_HEIGHT, 512, lines per frame
CNT_W, 20, pixel counter width; must hold IMG_WIDTH*IMG_HEIGHT
ALE_TIMEOUT, 4096, max cycles spent in ALE_WAIT before forced advance

Ports:
ACLK  in  1  global clock
ARESETn  in  1  asynchronous active-low reset
enable  in  1  start or continue frame processing
s_valid  in  1  S_AXIS_TVALID
s_last  in  1  S_AXIS_TLAST, used only for checking
fifo_ready  in  1  !axis_prog_full from the output buffer
s_ready  out  1  S_AXIS_TREADY
ale_done  in  1  ALE result valid (level)
ale_clear  out  1  one-cycle pulse that restarts ALE for a new frame
ale_enable  out  1  ALE clock/valid enable
te_enable  out  1  TE_SRSC clock/valid enable
m_valid  in  1  M_AXIS_TVALID
m_ready  in  1  M_AXIS_TREADY
m_last  out  1  M_AXIS_TLAST
frame_done  out  1  one-cycle pulse after the last output beat
state  out  3  current state code
tlast_err  out  1  sticky input framing error
ale_timeout  out  1  sticky ALE timeout flag

Behaviour:
- N = IMG_WIDTH*IMG_HEIGHT.
- in_beat = s_valid & s_ready.
- out_beat = m_valid & m_ready.
- Reset (async assert, sync release): state = IDLE, all counters = 0, all outputs = 0.
- States: IDLE=0, ALE_PASS=1, ALE_WAIT=2, DEHAZE_PASS=3, DRAIN=4.
- IDLE:
  - s_ready = 0.
  - If enable = 1: go to ALE_PASS, pulse ale_clear for exactly that transition cycle, clear tlast_err and ale_timeout.
- ALE_PASS:
  - ale_enable = 1.
  - s_ready = fifo_ready.
  - in_cnt increments on each in_beat.
  - On in_beat with in_cnt = N-1: in_cnt <= 0, go to ALE_WAIT.
- ALE_WAIT:
  - s_ready = 0, ale_enable = 1, wait_cnt increments each cycle.
  - If ale_done = 1: go to DEHAZE_PASS.
  - Else if wait_cnt = ALE_TIMEOUT-1: set ale_timeout and go to DEHAZE_PASS.
  - wait_cnt clears on exit.
- DEHAZE_PASS:
  - te_enable = 1.
  - s_ready = fifo_ready.
  - Input counted as in ALE_PASS.
  - On the last in_beat: go to DRAIN.
  - If the final out_beat occurs in the same cycle: go directly to IDLE.
- DRAIN:
  - te_enable = 1, s_ready = 0.
  - On the final out_beat: go to IDLE.
- Output counting:
  - out_cnt increments on out_beat only in DEHAZE_PASS or DRAIN.
  - The final out_beat is the one with out_cnt = N-1; it resets out_cnt to 0.
  - Beats seen in other states are ignored.
- m_last = m_valid & (out_cnt = N-1) & state in {DEHAZE_PASS, DRAIN}. Combinational.
- frame_done is registered: high for one cycle, the cycle after the final out_beat.
- ale_enable and te_enable are decoded from the state register only (registered, glitch-free), because they feed the clock-gating latches. They are never high together.
- s_ready is combinational from the state register and fifo_ready. It never depends on s_valid.
- tlast_err:
  - Set on in_beat when (s_last = 1 and in_cnt != N-1) or (s_last = 0 and in_cnt = N-1).
  - Counting is unaffected.
  - Cleared only by the IDLE→ALE_PASS transition or reset.
- enable is sampled only in IDLE. Deasserting it mid-frame lets the current frame complete; the block then stays in IDLE.
- Back-to-back frames: with enable held high, IDLE lasts exactly one cycle.
- ARESETn asserted mid-frame returns the block to IDLE immediately. Counters are not preserved.

Test Plan:
Use IMG_WIDTH=4, IMG_HEIGHT=4 (N=16), ALE_TIMEOUT=8 for all scenarios.

1. Nominal frame: enable=1, 16 beats, ale_done after 3 cycles, 16 more beats, 16 output beats → states 0→1→2→3→4→0; m_last only on the 16th output beat; one frame_done pulse; ale_clear pulses once.
2. Backpressure: toggle fifo_ready every cycle during both passes → s_ready follows fifo_ready; in_cnt advances only on handshakes; ALE_WAIT is entered after exactly 16 accepted beats.
3. ALE timeout: hold ale_done=0 → exactly 8 cycles in ALE_WAIT, then ale_timeout=1 and state=3; ale_timeout clears at the next frame start.
4. Framing error: s_last=1 on beat 10 → tlast_err=1 from the next cycle; frame still completes after 16 beats; s_last=0 on beat 16 keeps tlast_err=1.
5. Output stall and coincidence: hold m_ready=0 in DRAIN → m_last stays high with m_valid and no frame_done; separately, make the last input and last output beats coincide → direct transition 3→0.
6. Reset mid-DEHAZE_PASS (in_cnt=7): deassert ARESETn → all outputs 0 asynchronously; after release with enable=1, ale_clear pulses and in_cnt restarts at 0.
